cpu_run_controller: RTL and testbench
=====================================

Name: cpu_run_controller

Overview:
- Sequencer that sits in front of the 8-bit single-cycle microprocessor core.
- Holds a small program store, loaded byte-by-byte over a valid/ready handshake.
- Serves `instruction` combinationally from the core's current PC.
- Gates the core with a clock enable and a core reset, giving run / single-step / halt control and end-of-program detection.

Parameters:
- DEPTH, 32, program store entries (power of two, 2..256).
- CNT_W, 16, width of the executed-instruction counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- load_start  in  1  begin a new program load (accepted in IDLE or HALT).
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  8  instruction byte to store.
- load_ready  out  1  store can accept a byte.
- load_done  in  1  end of load; program length latched.
- run_req  in  1  start free-running execution.
- step_req  in  1  execute exactly one instruction.
- halt_req  in  1  stop execution.
- pc_in  in  8  core PCOutput.
- instruction  out  8  instruction for the core.
- core_en  out  1  core advances this cycle.
- core_rst  out  1  reset to core (drives core RST).
- state  out  3  FSM state encoding.
- prog_len  out  8  number of bytes loaded.
- instr_count  out  CNT_W  instructions executed since last load.
- overflow  out  1  sticky: byte offered while store full.

Behaviour:
- Reset: state=IDLE, prog_len=0, wr_ptr=0, instr_count=0, overflow=0. Outputs after reset: load_ready=0, core_en=0, core_rst=1. Store contents are not reset.
- States: IDLE=0, LOAD=1, HALT=2, RUN=3, STEP=4.
- IDLE:
  - load_start -> LOAD. On entry, wr_ptr=0, overflow=0, instr_count=0.
- LOAD:
  - load_ready = (wr_ptr < DEPTH).
  - A byte is written when load_valid && load_ready: mem[wr_ptr] = load_data, then wr_ptr+1.
  - load_valid while full: byte dropped, overflow set.
  - load_done: prog_len = wr_ptr, including a byte written in the same cycle. Next state is HALT if that length > 0, else IDLE.
  - load_done takes effect together with any same-cycle write.
- HALT:
  - Priority halt_req > step_req > run_req > load_start.
  - step_req -> STEP; run_req -> RUN; load_start -> LOAD (clears as above).
- RUN:
  - stop = (pc_in >= prog_len) OR halt_req.
  - core_en = !stop.
  - stop -> HALT in the next cycle; otherwise remain in RUN.
- STEP:
  - core_en = (pc_in < prog_len) for exactly one cycle, then -> HALT unconditionally.
  - halt_req in STEP suppresses core_en.
- core_rst = 1 in IDLE and LOAD; 0 otherwise. The core therefore restarts at PC 0 after every load.
- instruction = mem[pc_in] if pc_in < prog_len, else 8'h00. It is combinational, zero latency, because the core is single-cycle.
- instr_count increments every cycle core_en=1 and saturates at all-ones.
- load_ready=0 outside LOAD. Handshake inputs are ignored in states where they are not listed.
- RST at any time, including mid-load or mid-run, returns to IDLE in the next cycle, with core_rst asserted that cycle.
- pc_in wrap from 255 to 0 needs no special case: the stop test covers it.

Optional Feature:
- BREAKPOINT_EN adds inputs bp_addr[7:0] and bp_enable, and output bp_hit (1-cycle pulse).
- In RUN, pc_in == bp_addr with bp_enable=1 counts as stop: core_en=0 that cycle, bp_hit=1, next state HALT. The breakpoint instruction is not executed.
- STEP ignores the breakpoint, so stepping from a breakpoint always advances.
- Without the macro, the ports are absent and no breakpoint logic exists.

Decomposition:
- Shared package holds:
  - state typedef/localparams (IDLE..STEP);
  - NOP_INSTR = 8'h00;
  - opcode field position [7:6] for future decode.
- One natural sub-module: prog_store, a DEPTH x 8 single-write, async-read array with a write pointer and full flag.

Test Plan:
- Load 4 bytes (8'h12, 8'h47, 8'h8B, 8'hC1) then load_done -> prog_len=4, state=HALT, core_rst=0. With pc_in=2, instruction=8'h8B.
- run_req with core PC advancing 0..4 -> core_en high for 4 cycles, low when pc_in=4, state=HALT, instr_count=4.
- In HALT with pc_in=1, pulse step_req -> core_en high exactly 1 cycle, instr_count +1, back to HALT.
- Offer DEPTH+2 bytes -> load_ready drops after DEPTH writes, overflow=1, prog_len=DEPTH on load_done.
- RST asserted mid-RUN -> next cycle state=IDLE, core_en=0, core_rst=1, instr_count=0. load_done with 0 bytes -> IDLE.
- BREAKPOINT_EN, bp_addr=2, run from 0 -> core_en low at pc_in=2, bp_hit pulse, HALT. step_req then executes PC 2.

Source files
------------

// File: rtl/cpu_run_controller_pkg.sv
// Shared definitions for the CPU run controller: FSM state encoding,
// the NOP instruction served outside the loaded program, and the opcode
// field position reserved for future decode.
package cpu_run_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HALT = 3'd2,
    ST_RUN  = 3'd3,
    ST_STEP = 3'd4
  } runState_e;

  localparam logic [7:0] NOP_INSTR  = 8'h00;
  localparam int         OPCODE_MSB = 7;
  localparam int         OPCODE_LSB = 6;

  function automatic logic [1:0] opcodeOf(input logic [7:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/cpu_run_controller_prog_store.sv
// Program store: DEPTH x 8 array, one write port fed by an internal write
// pointer, one asynchronous read port addressed by the core PC.
// The array contents are never reset; only the pointer is.
module cpu_run_controller_prog_store #(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wrValid,
  input  logic [7:0]               wrData,
  input  logic [$clog2(DEPTH)-1:0] rdAddr,
  output logic [7:0]               rdData,
  output logic [$clog2(DEPTH):0]   wrPtr,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0] mem [DEPTH];
  logic       doWrite;

  assign full    = (wrPtr == PW'(DEPTH));
  assign doWrite = wrValid && !full;
  assign rdData  = mem[rdAddr];

  // Write pointer: restarts at every new load, stops advancing once full.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wrPtr <= '0;
    end else if (doWrite) begin
      wrPtr <= wrPtr + 1'b1;
    end
  end

  // Array write; bytes offered while full are dropped here.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem[wrPtr[AW-1:0]] <= wrData;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller for the 8-bit single-cycle core: loads the program store,
// serves instructions from the core PC, and gates the core through core_en
// and core_rst with run / single-step / halt control.
// Optional build macro: BREAKPOINT_EN adds bp_addr, bp_enable and bp_hit.
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  output logic             load_ready,
  input  logic             load_done,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic [7:0]       pc_in,
  output logic [7:0]       instruction,
  output logic             core_en,
  output logic             core_rst,
  output logic [2:0]       state,
  output logic [7:0]       prog_len,
  output logic [CNT_W-1:0] instr_count,
  output logic             overflow
`ifdef BREAKPOINT_EN
  ,
  input  logic [7:0]       bp_addr,
  input  logic             bp_enable,
  output logic             bp_hit
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  runState_e curState, nxtState;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] lenNow;
  logic [7:0]    storeData;
  logic          storeFull;
  logic          storeWr;
  logic          loadEntry;
  logic          pcInProg;
  logic          runStop;

  // A full 256-entry store cannot be expressed in 8 bits; report 255.
  function automatic logic [7:0] satLen(input logic [PW-1:0] n);
    logic [15:0] w;
    w = 16'(n);
    return (w > 16'd255) ? 8'hFF : w[7:0];
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  cpu_run_controller_prog_store #(.DEPTH(DEPTH)) u_store (
    .clk     (clk),
    .rst     (RST),
    .clr     (loadEntry),
    .wrValid (storeWr),
    .wrData  (load_data),
    .rdAddr  (pc_in[AW-1:0]),
    .rdData  (storeData),
    .wrPtr   (wrPtr),
    .full    (storeFull)
  );

  // Store handshake and instruction fetch; the PC range check also keeps
  // stale bytes from a longer earlier program from reaching the core.
  always_comb begin
    storeWr     = (curState == ST_LOAD) && load_valid;
    load_ready  = (curState == ST_LOAD) && !storeFull;
    lenNow      = wrPtr + PW'(storeWr && !storeFull);
    pcInProg    = (pc_in < prog_len);
    instruction = pcInProg ? storeData : NOP_INSTR;
    core_rst    = (curState == ST_IDLE) || (curState == ST_LOAD);
    state       = curState;
  end

`ifdef BREAKPOINT_EN
  logic bpMatch;
  // Breakpoint compare; only reported while free-running.
  always_comb begin
    bpMatch = bp_enable && (pc_in == bp_addr);
    bp_hit  = (curState == ST_RUN) && bpMatch;
  end
`endif

  // Next-state and core enable.
  always_comb begin
    nxtState  = curState;
    loadEntry = 1'b0;
    core_en   = 1'b0;
    runStop   = 1'b0;
    case (curState)
      ST_IDLE: begin
        if (load_start) begin
          nxtState  = ST_LOAD;
          loadEntry = 1'b1;
        end
      end
      ST_LOAD: begin
        if (load_done) begin
          nxtState = (lenNow != '0) ? ST_HALT : ST_IDLE;
        end
      end
      ST_HALT: begin
        if (halt_req) begin
          nxtState = ST_HALT;
        end else if (step_req) begin
          nxtState = ST_STEP;
        end else if (run_req) begin
          nxtState = ST_RUN;
        end else if (load_start) begin
          nxtState  = ST_LOAD;
          loadEntry = 1'b1;
        end
      end
      ST_RUN: begin
`ifdef BREAKPOINT_EN
        runStop = !pcInProg || halt_req || bpMatch;
`else
        runStop = !pcInProg || halt_req;
`endif
        core_en = !runStop;
        if (runStop) begin
          nxtState = ST_HALT;
        end
      end
      ST_STEP: begin
        core_en  = pcInProg && !halt_req;
        nxtState = ST_HALT;
      end
      default: begin
        nxtState = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (RST) begin
      curState <= ST_IDLE;
    end else begin
      curState <= nxtState;
    end
  end

  // Program length, latched at the end of a load including a same-cycle byte.
  always_ff @(posedge clk) begin
    if (RST) begin
      prog_len <= 8'h00;
    end else if ((curState == ST_LOAD) && load_done) begin
      prog_len <= satLen(lenNow);
    end
  end

  // Executed-instruction counter, cleared when a new load begins.
  always_ff @(posedge clk) begin
    if (RST || loadEntry) begin
      instr_count <= '0;
    end else if (core_en) begin
      instr_count <= satInc(instr_count);
    end
  end

  // Sticky overflow: a byte was offered while the store was full.
  always_ff @(posedge clk) begin
    if (RST || loadEntry) begin
      overflow <= 1'b0;
    end else if (storeWr && storeFull) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller: directed loads/run/step plus
// randomized load lengths, byte gaps, halt points and step positions, all
// checked against a bench-side model of program, length and counter.
module tb_cpu_run_controller;

  localparam int DEPTH   = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;
  localparam int S_IDLE  = 0;
  localparam int S_LOAD  = 1;
  localparam int S_HALT  = 2;
  localparam int S_RUN   = 3;
  localparam int S_STEP  = 4;

  logic             clk;
  logic             RST;
  logic             load_start, load_valid, load_done;
  logic [7:0]       load_data;
  logic             load_ready;
  logic             run_req, step_req, halt_req;
  logic [7:0]       pc_in;
  logic [7:0]       instruction;
  logic             core_en, core_rst;
  logic [2:0]       state;
  logic [7:0]       prog_len;
  logic [CNT_W-1:0] instr_count;
  logic             overflow;
  logic [7:0]       bp_addr;
  logic             bp_enable;
  logic             bp_hit;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] modelMem [DEPTH];
  int         modelLen = 0;
  int         modelCount = 0;
  logic [7:0] fixedBytes [$];
  bit         bpOn = 0;
  int         bpAt = 0;

  cpu_run_controller #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .RST         (RST),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .run_req     (run_req),
    .step_req    (step_req),
    .halt_req    (halt_req),
    .pc_in       (pc_in),
    .instruction (instruction),
    .core_en     (core_en),
    .core_rst    (core_rst),
    .state       (state),
    .prog_len    (prog_len),
    .instr_count (instr_count),
    .overflow    (overflow)
`ifdef BREAKPOINT_EN
    ,
    .bp_addr     (bp_addr),
    .bp_enable   (bp_enable),
    .bp_hit      (bp_hit)
`endif
  );

`ifndef BREAKPOINT_EN
  assign bp_hit = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int expInstr(input int pc);
    return (pc < modelLen) ? int'(modelMem[pc]) : 0;
  endfunction

  function automatic int bumped(input int c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  task automatic idleInputs();
    load_start = 0; load_valid = 0; load_done = 0; load_data = 8'h00;
    run_req = 0; step_req = 0; halt_req = 0; pc_in = 8'h00;
    bp_addr = 8'(bpAt); bp_enable = bpOn;
  endtask

  // Load nBytes (from fixedBytes when non-empty, else random) with random
  // valid gaps; withLast puts load_done on the final accepted byte.
  task automatic doLoad(input int nBytes, input bit withLast);
    int written;
    bit ovf;
    bit fin;
    int i;
    logic [7:0] d;
    bit v;
    written = 0; ovf = 0; fin = 0; i = 0;
    load_start = 1;
    #1;
    check("load_start_en", 32'(core_en), 0);
    cyc();
    load_start = 0;
    #1;
    check("load_state", 32'(state), S_LOAD);
    check("load_core_rst", 32'(core_rst), 1);
    check("load_cnt_clr", 32'(instr_count), 0);
    check("load_ovf_clr", 32'(overflow), 0);
    while (i < nBytes && !fin) begin
      v = (fixedBytes.size() != 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      d = (fixedBytes.size() != 0) ? fixedBytes[i] : 8'($urandom);
      load_valid = v;
      load_data  = d;
      load_done  = withLast && v && (i == nBytes - 1);
      #1;
      check("load_ready", 32'(load_ready), 32'(written < DEPTH));
      check("load_core_en", 32'(core_en), 0);
      cyc();
      if (v) begin
        if (written < DEPTH) begin
          modelMem[written] = d;
          written++;
        end else begin
          ovf = 1;
        end
        if (load_done) fin = 1;
        i++;
      end
    end
    load_valid = 0;
    if (!fin) begin
      load_done = 1;
      #1;
      cyc();
    end
    load_done = 0;
    #1;
    modelLen   = written;
    modelCount = 0;
    check("load_len", 32'(prog_len), 32'(written));
    check("load_end_state", 32'(state), (written > 0) ? S_HALT : S_IDLE);
    check("load_ovf", 32'(overflow), 32'(ovf));
    check("load_ready_off", 32'(load_ready), 0);
    check("load_end_rst", 32'(core_rst), (written > 0) ? 0 : 1);
  endtask

  // Free run from PC 0; the bench plays the core, advancing PC whenever the
  // rules say the instruction executes. halt_req is raised at iteration haltAt.
  task automatic doRun(input int haltAt);
    int  pc;
    bit  stopped;
    bit  expEn;
    bit  expHit;
    pc = 0; stopped = 0;
    run_req = 1;
    pc_in = 8'h00;
    #1;
    check("run_req_en", 32'(core_en), 0);
    cyc();
    run_req = 0;
    for (int k = 0; k < 300 && !stopped; k++) begin
      pc_in    = 8'(pc);
      halt_req = (k == haltAt);
      #1;
      expHit = bpOn && (pc == bpAt);
      expEn  = (pc < modelLen) && !halt_req && !expHit;
      check("run_state", 32'(state), S_RUN);
      check("run_en", 32'(core_en), 32'(expEn));
      check("run_instr", 32'(instruction), 32'(expInstr(pc)));
      check("run_bp_hit", 32'(bp_hit), 32'(expHit));
      cyc();
      if (expEn) begin
        modelCount = bumped(modelCount);
        pc++;
      end else begin
        stopped = 1;
      end
    end
    check("run_bound", 32'(stopped), 1);
    halt_req = 0;
    #1;
    check("run_end_state", 32'(state), S_HALT);
    check("run_count", 32'(instr_count), 32'(modelCount));
    check("run_end_hit", 32'(bp_hit), 0);
  endtask

  task automatic doStep(input int pc, input bit haltInStep);
    bit expEn;
    step_req = 1;
    pc_in    = 8'(pc);
    #1;
    check("step_req_en", 32'(core_en), 0);
    cyc();
    step_req = 0;
    halt_req = haltInStep;
    #1;
    expEn = (pc < modelLen) && !haltInStep;
    check("step_state", 32'(state), S_STEP);
    check("step_en", 32'(core_en), 32'(expEn));
    cyc();
    halt_req = 0;
    if (expEn) modelCount = bumped(modelCount);
    #1;
    check("step_back", 32'(state), S_HALT);
    check("step_en_off", 32'(core_en), 0);
    check("step_count", 32'(instr_count), 32'(modelCount));
  endtask

  initial begin
    idleInputs();
    RST = 1;
    cyc();
    cyc();
    RST = 0;
    #1;
    check("rst_state", 32'(state), S_IDLE);
    check("rst_ready", 32'(load_ready), 0);
    check("rst_en", 32'(core_en), 0);
    check("rst_core_rst", 32'(core_rst), 1);
    check("rst_len", 32'(prog_len), 0);
    check("rst_cnt", 32'(instr_count), 0);
    check("rst_ovf", 32'(overflow), 0);

    // Directed 4-byte program.
    fixedBytes = '{8'h12, 8'h47, 8'h8B, 8'hC1};
    doLoad(4, 0);
    fixedBytes.delete();
    pc_in = 8'd2;
    #1;
    check("fixed_instr2", 32'(instruction), 32'h8B);
    pc_in = 8'd4;
    #1;
    check("fixed_instr_past", 32'(instruction), 0);
    doRun(1000);
    check("fixed_run_cnt", 32'(instr_count), 4);
    doStep(1, 0);
    check("fixed_step_cnt", 32'(instr_count), 5);
    doStep(7, 0);
    doStep(0, 1);

    // HALT priority: halt beats everything, then step beats run and load.
    halt_req = 1; step_req = 1; run_req = 1; load_start = 1; pc_in = 8'd200;
    cyc();
    check("prio_halt", 32'(state), S_HALT);
    halt_req = 0;
    cyc();
    step_req = 0; run_req = 0; load_start = 0;
    check("prio_step", 32'(state), S_STEP);
    check("prio_step_en", 32'(core_en), 0);
    cyc();
    check("prio_back", 32'(state), S_HALT);

    // Overflow: DEPTH+2 bytes, done in a separate cycle.
    doLoad(DEPTH + 2, 0);
    check("ovf_len", 32'(prog_len), DEPTH);
    doRun(1000);
    check("sat_cnt", 32'(instr_count), CNT_MAX);

    // Randomized loads, runs and steps.
    for (int it = 0; it < 14; it++) begin
      doLoad($urandom_range(0, DEPTH + 3), 1'($urandom_range(0, 1)));
      for (int r = 0; r < 3; r++) begin
        int p;
        p = $urandom_range(0, DEPTH + 4);
        pc_in = 8'(p);
        #1;
        check("rand_instr", 32'(instruction), 32'(expInstr(p)));
      end
      if (modelLen > 0) begin
        if ($urandom_range(0, 2) == 0) begin
          doStep($urandom_range(0, modelLen + 2), 1'($urandom_range(0, 3) == 0));
        end else begin
          doRun($urandom_range(0, modelLen + 3));
        end
      end
    end

    // Zero-length load returns to IDLE.
    doLoad(0, 0);
    check("empty_state", 32'(state), S_IDLE);

    // RST in the middle of a run.
    doLoad(20, 1);
    if (modelLen > 3) begin
      run_req = 1;
      cyc();
      run_req = 0;
      for (int k = 0; k < 3; k++) begin
        pc_in = 8'(k);
        cyc();
      end
      RST = 1;
      cyc();
      RST = 0;
      pc_in = 8'd1;
      #1;
      modelLen = 0;
      modelCount = 0;
      check("midrst_state", 32'(state), S_IDLE);
      check("midrst_en", 32'(core_en), 0);
      check("midrst_core_rst", 32'(core_rst), 1);
      check("midrst_cnt", 32'(instr_count), 0);
      check("midrst_len", 32'(prog_len), 0);
    end

`ifdef BREAKPOINT_EN
    fixedBytes = '{8'h12, 8'h47, 8'h8B, 8'hC1};
    doLoad(4, 1);
    fixedBytes.delete();
    bpOn = 1; bpAt = 2;
    bp_addr = 8'd2; bp_enable = 1;
    doRun(1000);
    check("bp_run_cnt", 32'(instr_count), 2);
    doStep(2, 0);
    check("bp_step_cnt", 32'(instr_count), 3);
    bpOn = 0; bp_enable = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
